// File: rtl/mips_defs.sv
// Shared MIPS pipeline constants: reset PC, instruction-memory window and the NOP encoding.
package mips_defs;

    localparam logic [31:0] RESET_PC  = 32'h0000_3000;
    localparam logic [31:0] IM_BASE   = 32'h0000_3000;
    localparam int          IM_DEPTH  = 4096;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats stall, stall holds, otherwise latch the fetch result.
// A fetch fault latches a NOP bubble with the exception bit set.
module if_id_reg
    import mips_defs::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] instr_f,
    input  logic [31:0] pc_f,
    input  logic        fault_f,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic        valid_d,
    output logic        exc_d
);

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_d <= NOP_INSTR;
            pc_d    <= 32'h0;
            valid_d <= 1'b0;
            exc_d   <= 1'b0;
        end else if (flush) begin
            instr_d <= NOP_INSTR;
            pc_d    <= pc_f;
            valid_d <= 1'b0;
            exc_d   <= 1'b0;
        end else if (!stall) begin
            pc_d <= pc_f;
            if (fault_f) begin
                instr_d <= NOP_INSTR;
                valid_d <= 1'b0;
                exc_d   <= 1'b1;
            end else begin
                instr_d <= instr_f;
                valid_d <= 1'b1;
                exc_d   <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// MIPS IF stage: PC register, fetch-address fault check, stall counter and the IF/ID register.
// Define IF_ADDR_CHECK_EN to enable the fetch-address fault check (exc_D).
module fetch_stage #(
    parameter logic [31:0] RESET_PC = mips_defs::RESET_PC,
    parameter logic [31:0] IM_BASE  = mips_defs::IM_BASE,
    parameter int          IM_DEPTH = mips_defs::IM_DEPTH
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] npc,
    input  logic        stall,
    input  logic        flush,
    output logic [31:0] im_addr,
    input  logic [31:0] im_rdata,
    output logic [31:0] pc_F,
    output logic [31:0] instr_D,
    output logic [31:0] pc_D,
    output logic        valid_D,
    output logic        exc_D,
    output logic [31:0] stall_cnt
);

    logic fetch_fault;

    assign im_addr = pc_F;

`ifdef IF_ADDR_CHECK_EN
    // 33-bit end address so a window touching 2^32 cannot wrap the comparison.
    localparam logic [32:0] IM_END = {1'b0, IM_BASE} + (33'(IM_DEPTH) << 2);

    assign fetch_fault = (pc_F[1:0] != 2'b00)
                       || (pc_F < IM_BASE)
                       || ({1'b0, pc_F} >= IM_END);
`else
    assign fetch_fault = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_F <= RESET_PC;
        end else if (!stall) begin
            pc_F <= npc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= 32'h0;
        end else if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'h1;
        end
    end

    if_id_reg u_if_id_reg (
        .clk     (clk),
        .reset   (reset),
        .stall   (stall),
        .flush   (flush),
        .instr_f (im_rdata),
        .pc_f    (pc_F),
        .fault_f (fetch_fault),
        .instr_d (instr_D),
        .pc_d    (pc_D),
        .valid_d (valid_D),
        .exc_d   (exc_D)
    );

endmodule
